// File: rtl/cpu_debug_ctrl_if.sv
// Host-side program-write and command handshakes plus the registered
// instruction-memory write port driven by the debug controller.
interface cpu_debug_ctrl_if #(
    parameter int ADDR_W  = 4,
    parameter int INSTR_W = 8,
    parameter int STEP_W  = 8
);
    logic               prog_valid;
    logic               prog_ready;
    logic [ADDR_W-1:0]  prog_addr;
    logic [INSTR_W-1:0] prog_data;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [STEP_W-1:0]  cmd_count;
    logic               imem_we;
    logic [ADDR_W-1:0]  imem_waddr;
    logic [INSTR_W-1:0] imem_wdata;

    modport master (
        output prog_valid, prog_addr, prog_data, cmd_valid, cmd_op, cmd_count,
        input  prog_ready, cmd_ready, imem_we, imem_waddr, imem_wdata
    );

    modport slave (
        input  prog_valid, prog_addr, prog_data, cmd_valid, cmd_op, cmd_count,
        output prog_ready, cmd_ready, imem_we, imem_waddr, imem_wdata
    );
endinterface

// File: rtl/cpu_debug_ctrl.sv
// Debug controller: loads instruction memory, then resets or single-steps the
// core by cycles or retired instructions, with halt and PC breakpoint.
module cpu_debug_ctrl #(
    parameter int ADDR_W  = 4,
    parameter int INSTR_W = 8,
    parameter int STEP_W  = 8
) (
    input  logic              cpu_clk,
    input  logic              cpu_reset,
    cpu_debug_ctrl_if.slave   bus,
    input  logic              halt_req,
    input  logic              bp_en,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic [ADDR_W-1:0] core_pc,
    input  logic              core_instr_done,
    output logic              core_reset,
    output logic              core_ce,
    output logic              busy,
    output logic              done,
    output logic              bp_hit
);
    typedef enum logic [1:0] {IDLE, CORE_RST, STEP_CYC, STEP_INS} state_t;

    state_t             state;
    logic [STEP_W-1:0]  cnt;
    logic               we_q;
    logic [ADDR_W-1:0]  waddr_q;
    logic [INSTR_W-1:0] wdata_q;
    logic               idle, active, bp_match, tick, last, stop;

    assign idle     = (state == IDLE);
    assign active   = (state == STEP_CYC) || (state == STEP_INS);
    assign bp_match = core_instr_done && bp_en && (core_pc == bp_addr);
    assign tick     = (state == STEP_CYC) || ((state == STEP_INS) && core_instr_done);
    // A zero count never reaches 1, so free-run mode needs no special case here.
    assign last     = tick && (cnt == STEP_W'(1));
    assign stop     = active && (halt_req || bp_match || last);

    assign bus.prog_ready = idle && !cpu_reset;
    assign bus.cmd_ready  = idle && !cpu_reset && !bus.prog_valid;
    assign bus.imem_we    = we_q;
    assign bus.imem_waddr = waddr_q;
    assign bus.imem_wdata = wdata_q;
    assign core_reset     = cpu_reset || (state == CORE_RST);

    always_ff @(posedge cpu_clk) begin
        if (cpu_reset) begin
            state   <= IDLE;
            core_ce <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bp_hit  <= 1'b0;
            cnt     <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            done    <= 1'b0;
            we_q    <= bus.prog_valid && bus.prog_ready;
            waddr_q <= bus.prog_addr;
            wdata_q <= bus.prog_data;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        bp_hit <= 1'b0;
                        cnt    <= bus.cmd_count;
                        case (bus.cmd_op)
                            2'b00: begin state <= CORE_RST; core_ce <= 1'b1; busy <= 1'b1; end
                            2'b01: begin state <= STEP_CYC; core_ce <= 1'b1; busy <= 1'b1; end
                            2'b10: begin state <= STEP_INS; core_ce <= 1'b1; busy <= 1'b1; end
                            default: done <= 1'b1;
                        endcase
                    end
                end
                CORE_RST: begin
                    state   <= IDLE;
                    core_ce <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end
                default: begin
                    if (stop) begin
                        state   <= IDLE;
                        core_ce <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        if (bp_match) bp_hit <= 1'b1;
                    end else if (tick && cnt != '0) begin
                        cnt <= cnt - STEP_W'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_debug_ctrl.sv
// Randomized bench for cpu_debug_ctrl: each command's stop cycle is predicted
// from the pre-generated per-cycle stimulus by an event-based reference model.
module tb_cpu_debug_ctrl;
    localparam int ADDR_W = 4, INSTR_W = 8, STEP_W = 8;
    localparam int L = 40;

    logic clk = 1'b0;
    logic rst;
    logic halt_req, bp_en, core_instr_done;
    logic [ADDR_W-1:0] bp_addr, core_pc;
    logic core_reset, core_ce, busy, done, bp_hit;

    cpu_debug_ctrl_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .STEP_W(STEP_W)) bus ();

    cpu_debug_ctrl #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .STEP_W(STEP_W)) dut (
        .cpu_clk(clk), .cpu_reset(rst), .bus(bus),
        .halt_req(halt_req), .bp_en(bp_en), .bp_addr(bp_addr),
        .core_pc(core_pc), .core_instr_done(core_instr_done),
        .core_reset(core_reset), .core_ce(core_ce), .busy(busy),
        .done(done), .bp_hit(bp_hit)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    bit st_done [0:63];
    bit st_halt [0:63];
    logic [ADDR_W-1:0] st_pc [0:63];
    bit exp_hit;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clr_stim();
        for (int k = 0; k < 64; k++) begin
            st_done[k] = 1'b0; st_halt[k] = 1'b0; st_pc[k] = '0;
        end
    endtask

    task automatic rnd_stim();
        for (int k = 0; k < 64; k++) begin
            st_done[k] = ($urandom_range(2) == 0);
            st_halt[k] = ($urandom_range(39) == 0);
            st_pc[k]   = ADDR_W'($urandom_range(15));
        end
        st_halt[L] = 1'b1;
    endtask

    // Stop = earliest of halt, breakpoint retire, or count reached (cycles or retires).
    function automatic int model_stop(input int op, input int n);
        int pulses = 0;
        exp_hit = 1'b0;
        if (op == 0) return 1;
        if (op == 3) return 0;
        for (int k = 1; k <= L; k++) begin
            bit s = 1'b0;
            if (st_halt[k]) s = 1'b1;
            if (st_done[k] && bp_en && st_pc[k] == bp_addr) begin s = 1'b1; exp_hit = 1'b1; end
            if (op == 1 && n != 0 && k == n) s = 1'b1;
            if (op == 2 && st_done[k]) begin
                pulses++;
                if (n != 0 && pulses == n) s = 1'b1;
            end
            if (s) return k;
        end
        return L;
    endfunction

    task automatic run_cmd(input int op, input int n);
        int s;
        s = model_stop(op, n);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'(op);
        bus.cmd_count = STEP_W'(n);
        #1 chk("cmd_ready", 32'(bus.cmd_ready), 32'd1);
        for (int k = 1; k <= s + 2; k++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            chk("core_ce", 32'(core_ce), 32'(k <= s));
            chk("busy", 32'(busy), 32'(k <= s));
            chk("done", 32'(done), 32'(k == s + 1));
            chk("bp_hit", 32'(bp_hit), 32'((k > s) && exp_hit));
            if (op == 0) chk("core_reset", 32'(core_reset), 32'(k == 1));
            if (k <= s) begin
                halt_req = st_halt[k]; core_instr_done = st_done[k]; core_pc = st_pc[k];
            end else begin
                halt_req = 1'b0; core_instr_done = 1'b0; core_pc = '0;
            end
        end
    endtask

    initial begin
        logic [INSTR_W-1:0] pd [0:11];
        rst = 1'b1; halt_req = 0; bp_en = 0; bp_addr = '0; core_pc = '0; core_instr_done = 0;
        bus.prog_valid = 0; bus.prog_addr = '0; bus.prog_data = '0;
        bus.cmd_valid = 0; bus.cmd_op = '0; bus.cmd_count = '0;
        clr_stim();
        repeat (3) @(negedge clk);
        chk("rst core_reset", 32'(core_reset), 32'd1);
        chk("rst prog_ready", 32'(bus.prog_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst core_ce", 32'(core_ce), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst bp_hit", 32'(bp_hit), 32'd0);
        chk("rst imem_we", 32'(bus.imem_we), 32'd0);
        chk("rst core_reset off", 32'(core_reset), 32'd0);
        chk("idle prog_ready", 32'(bus.prog_ready), 32'd1);
        chk("idle cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // Back-to-back program writes; a concurrent command must lose.
        for (int i = 0; i <= 12; i++) begin
            if (i >= 1) begin
                chk("imem_we", 32'(bus.imem_we), 32'd1);
                chk("imem_waddr", 32'(bus.imem_waddr), 32'(i - 1));
                chk("imem_wdata", 32'(bus.imem_wdata), 32'(pd[i-1]));
                chk("prog no ce", 32'(core_ce), 32'd0);
            end
            if (i < 12) begin
                pd[i] = INSTR_W'($urandom);
                bus.prog_valid = 1'b1; bus.prog_addr = ADDR_W'(i); bus.prog_data = pd[i];
                bus.cmd_valid = (i == 5); bus.cmd_op = 2'b01; bus.cmd_count = 8'd3;
                #1 chk("prog_ready", 32'(bus.prog_ready), 32'd1);
                chk("cmd_ready blocked", 32'(bus.cmd_ready), 32'd0);
            end else begin
                bus.prog_valid = 1'b0; bus.cmd_valid = 1'b0;
            end
            @(negedge clk);
        end
        chk("imem_we off", 32'(bus.imem_we), 32'd0);
        chk("cmd lost busy", 32'(busy), 32'd0);

        // Halt while idle is ignored.
        halt_req = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle halt busy", 32'(busy), 32'd0);
            chk("idle halt done", 32'(done), 32'd0);
        end
        halt_req = 1'b0;

        clr_stim(); run_cmd(1, 4);
        clr_stim(); for (int k = 4; k < 64; k += 4) st_done[k] = 1'b1; run_cmd(2, 3);
        clr_stim(); bp_en = 1'b1; bp_addr = 4'b1011;
        for (int k = 1; k < 64; k += 2) begin st_done[k] = 1'b1; st_pc[k] = ADDR_W'(k % 8); end
        st_done[6] = 1'b1; st_pc[6] = 4'b1011;
        run_cmd(2, 0);
        clr_stim(); bp_en = 1'b0; st_halt[7] = 1'b1; run_cmd(1, 0);
        clr_stim(); run_cmd(0, 5);
        clr_stim(); run_cmd(3, 2);
        // Halt, breakpoint and count expiry in one cycle: one stop, bp_hit set.
        clr_stim(); bp_en = 1'b1; bp_addr = 4'd3;
        st_done[5] = 1'b1; st_pc[5] = 4'd3; st_halt[5] = 1'b1; run_cmd(1, 5);

        for (int t = 0; t < 40; t++) begin
            int op, n;
            rnd_stim();
            bp_en = 1'($urandom_range(1)); bp_addr = ADDR_W'($urandom_range(15));
            op = $urandom_range(3);
            n = ($urandom_range(3) == 0) ? 0 : $urandom_range(1, 20);
            run_cmd(op, n);
        end

        // Reset mid-command aborts without a done pulse.
        clr_stim(); bp_en = 1'b0;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'b01; bus.cmd_count = 8'd200;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            chk("long ce", 32'(core_ce), 32'd1);
        end
        rst = 1'b1;
        #1 chk("reset core_reset", 32'(core_reset), 32'd1);
        @(negedge clk);
        chk("abort ce", 32'(core_ce), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort core_reset", 32'(core_reset), 32'd1);
        rst = 1'b0;
        #1 chk("release core_reset", 32'(core_reset), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("post abort done", 32'(done), 32'd0);
            chk("post abort ce", 32'(core_ce), 32'd0);
        end
        chk("post abort cmd_ready", 32'(bus.cmd_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
